// File: rtl/arm_mc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arm_mc_pkg
// Description : Shared types and constants for the multicycle core writeback
//               path. It holds the writeback FSM state encoding, the PC
//               register index and the datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_mc_pkg;

  localparam int REG_AW = 4;
  localparam int DATA_W = 32;

  // Register 15 is the PC. Writes to it use the dedicated PC strobe.
  localparam logic [REG_AW-1:0] PC_IDX = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module      : wb_hazard_cmp
// Description : Compares one read-port address against the writes still
//               outstanding in the writeback sequencer. It reports a pending
//               hazard and, optionally, forwards the value being written.
//               Optional feature macro: REGFILE_WB_FWD_EN (forwarding).
// Ports       : ra                   - read address from the read stage
//               state, long_req      - sequencer state and long flag
//               beat_addr/beat_data  - beat currently driven
//               hi_addr/hi_data      - latched high word of a long request
//               pend                 - outstanding write to ra
//               fwd_hit/fwd_data     - forwarded value (0 when disabled)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hazard_cmp
  import arm_mc_pkg::*;
(
  input  logic [REG_AW-1:0] ra,
  input  wb_state_t         state,
  input  logic              long_req,
  input  logic [REG_AW-1:0] beat_addr,
  input  logic [DATA_W-1:0] beat_data,
  input  logic [REG_AW-1:0] hi_addr,
  input  logic [DATA_W-1:0] hi_data,
  output logic              pend,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic beat_match;
  logic hi_match;

  // The PC never reaches the register file, so reads of r15 never conflict.
  always_comb begin
    beat_match = (state != IDLE) && (ra == beat_addr) && (ra != PC_IDX);
    hi_match   = (state == BEAT_LO) && long_req && (ra == hi_addr) &&
                 (ra != PC_IDX);
  end

  assign pend = beat_match | hi_match;

`ifdef REGFILE_WB_FWD_EN
  // The high beat lands after the low beat. When rd_lo == rd_hi, the newest
  // value is therefore the high word.
  assign fwd_hit  = pend;
  assign fwd_data = hi_match   ? hi_data   :
                    beat_match ? beat_data : '0;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;

  logic unused_fwd_data;
  assign unused_fwd_data = ^{beat_data, hi_data};
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_wb_seq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_seq
// Description : Writeback sequencer for the single register-file write port.
//               It splits 32-bit and 64-bit results into one or two 32-bit
//               beats. Writes to r15 are steered to the PC strobe. It also
//               reports pending-write hazards to the read stage.
//               Optional feature macro: REGFILE_WB_FWD_EN (forwarding).
// Ports       : clk, reset (async, active-low)
//               req_*           - writeback request handshake and payload
//               rf_we/wa/wd     - register file write port (registered)
//               pc_we/pc_wd     - PC write strobe and data (registered)
//               ra1/ra2         - read addresses
//               pend1/pend2     - read address has an outstanding write
//               fwd1_*/fwd2_*   - forwarding hit and data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_seq
  import arm_mc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_long,
  input  logic [REG_AW-1:0]     req_rd_lo,
  input  logic [REG_AW-1:0]     req_rd_hi,
  input  logic [2*DATA_W-1:0]   req_data,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_wa,
  output logic [DATA_W-1:0]     rf_wd,
  output logic                  pc_we,
  output logic [DATA_W-1:0]     pc_wd,
  input  logic [REG_AW-1:0]     ra1,
  input  logic [REG_AW-1:0]     ra2,
  output logic                  pend1,
  output logic                  pend2,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [DATA_W-1:0]     fwd1_data,
  output logic [DATA_W-1:0]     fwd2_data
);

  wb_state_t         state_q, state_d;
  logic              long_q, long_d;
  logic [REG_AW-1:0] rd_hi_q, rd_hi_d;
  logic [DATA_W-1:0] hi_data_q, hi_data_d;
  logic [REG_AW-1:0] beat_addr_q, beat_addr_d;
  logic [DATA_W-1:0] beat_data_q, beat_data_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic              pc_we_q, pc_we_d;
  logic [DATA_W-1:0] pc_wd_q, pc_wd_d;

  logic ready_w;
  logic accept_w;
  logic beat_valid_w;

  // Only the low beat of a long request blocks new requests, because the
  // high beat still has to use the write port.
  always_comb begin
    ready_w = 1'b0;
    case (state_q)
      IDLE:    ready_w = 1'b1;
      BEAT_LO: ready_w = ~long_q;
      BEAT_HI: ready_w = 1'b1;
      default: ready_w = 1'b0;
    endcase
  end

  // Gating with the reset pin holds ready at 0 while reset is asserted and
  // lets it rise straight into IDLE once reset is released.
  assign req_ready = reset & ready_w;
  assign accept_w  = req_valid & req_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_w ? BEAT_LO : IDLE;
      BEAT_LO: begin
        if (long_q) begin
          state_d = BEAT_HI;
        end else begin
          state_d = accept_w ? BEAT_LO : IDLE;
        end
      end
      BEAT_HI: state_d = accept_w ? BEAT_LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------ beat / output logic
  always_comb begin
    long_d       = long_q;
    rd_hi_d      = rd_hi_q;
    hi_data_d    = hi_data_q;
    beat_addr_d  = beat_addr_q;
    beat_data_d  = beat_data_q;
    beat_valid_w = 1'b0;

    if (accept_w) begin
      long_d       = req_long;
      rd_hi_d      = req_rd_hi;
      hi_data_d    = req_data[2*DATA_W-1:DATA_W];
      beat_addr_d  = req_rd_lo;
      beat_data_d  = req_data[DATA_W-1:0];
      beat_valid_w = 1'b1;
    end else if (state_q == BEAT_LO && long_q) begin
      beat_addr_d  = rd_hi_q;
      beat_data_d  = hi_data_q;
      beat_valid_w = 1'b1;
    end

    rf_we_d = beat_valid_w && (beat_addr_d != PC_IDX);
    rf_wa_d = rf_we_d ? beat_addr_d : '0;
    rf_wd_d = rf_we_d ? beat_data_d : '0;
    pc_we_d = beat_valid_w && (beat_addr_d == PC_IDX);
    pc_wd_d = pc_we_d ? beat_data_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_q      <= 1'b0;
      rd_hi_q     <= '0;
      hi_data_q   <= '0;
      beat_addr_q <= '0;
      beat_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      pc_we_q     <= 1'b0;
      pc_wd_q     <= '0;
    end else begin
      long_q      <= long_d;
      rd_hi_q     <= rd_hi_d;
      hi_data_q   <= hi_data_d;
      beat_addr_q <= beat_addr_d;
      beat_data_q <= beat_data_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      pc_we_q     <= pc_we_d;
      pc_wd_q     <= pc_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign pc_we = pc_we_q;
  assign pc_wd = pc_wd_q;

  // -------------------------------------------------------- hazard detection
  wb_hazard_cmp u_cmp1 (
    .ra        (ra1),
    .state     (state_q),
    .long_req  (long_q),
    .beat_addr (beat_addr_q),
    .beat_data (beat_data_q),
    .hi_addr   (rd_hi_q),
    .hi_data   (hi_data_q),
    .pend      (pend1),
    .fwd_hit   (fwd1_hit),
    .fwd_data  (fwd1_data)
  );

  wb_hazard_cmp u_cmp2 (
    .ra        (ra2),
    .state     (state_q),
    .long_req  (long_q),
    .beat_addr (beat_addr_q),
    .beat_data (beat_data_q),
    .hi_addr   (rd_hi_q),
    .hi_data   (hi_data_q),
    .pend      (pend2),
    .fwd_hit   (fwd2_hit),
    .fwd_data  (fwd2_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_seq
// Description : Directed self-checking bench for regfile_wb_seq. It covers
//               reset, short, long, back-to-back, PC-redirect and same-register
//               requests, plus hazard reporting and reset during a beat.
//               Forwarding expectations follow REGFILE_WB_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_seq;

`ifdef REGFILE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_long;
  logic [3:0]  req_rd_lo;
  logic [3:0]  req_rd_hi;
  logic [63:0] req_data;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic [3:0]  ra1, ra2;
  logic        pend1, pend2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Shadow register file built from the writes that land on clock edges.
  logic [31:0] rf_model [16];
  int          wr_count = 0;

  regfile_wb_seq dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_long  (req_long),
    .req_rd_lo (req_rd_lo),
    .req_rd_hi (req_rd_hi),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .pc_we     (pc_we),
    .pc_wd     (pc_wd),
    .ra1       (ra1),
    .ra2       (ra2),
    .pend1     (pend1),
    .pend2     (pend2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rf_we === 1'b1) begin
      rf_model[rf_wa] <= rf_wd;
      wr_count        <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic lng, input logic [3:0] lo,
                       input logic [3:0] hi, input logic [63:0] d);
    req_valid = v;
    req_long  = lng;
    req_rd_lo = lo;
    req_rd_hi = hi;
    req_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
    ra1 = 4'd0;
    ra2 = 4'd0;
    tick();
    tick();
    vec_cnt++;
    if ({req_ready, rf_we, rf_wa, rf_wd, pc_we, pc_wd} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: ready=%b we=%b wa=%0d wd=%h pc_we=%b pc_wd=%h, want all 0",
               req_ready, rf_we, rf_wa, rf_wd, pc_we, pc_wd);
    end
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_ready_idle: got %b want 1", req_ready);
    end
  endtask

  task automatic test_short();
    drive(1'b1, 1'b0, 4'd3, 4'd9, 64'h0000_0000_DEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
    vec_cnt++;
    if ({rf_we, rf_wa, rf_wd, pc_we} !== {1'b1, 4'd3, 32'hDEADBEEF, 1'b0}) begin
      err_cnt++;
      $display("FAIL short_beat: we=%b wa=%0d wd=%h pc_we=%b, want 1/3/deadbeef/0",
               rf_we, rf_wa, rf_wd, pc_we);
    end
    // The ignored rd_hi (9) must not show up as a hazard.
    ra1 = 4'd9;
    ra2 = 4'd3;
    #1;
    vec_cnt++;
    if ({pend1, pend2} !== 2'b01) begin
      err_cnt++;
      $display("FAIL short_pend: pend1=%b pend2=%b, want 0/1", pend1, pend2);
    end
    tick();
    vec_cnt++;
    if ({rf_we, req_ready, pend2} !== 3'b010) begin
      err_cnt++;
      $display("FAIL short_idle: we=%b ready=%b pend2=%b, want 0/1/0", rf_we, req_ready, pend2);
    end
  endtask

  task automatic test_long();
    drive(1'b1, 1'b1, 4'd4, 4'd5, 64'h1111_2222_3333_4444);
    tick();
    ra1 = 4'd5;
    ra2 = 4'd4;
    #1;
    vec_cnt++;
    if ({rf_we, rf_wa, rf_wd, req_ready} !== {1'b1, 4'd4, 32'h33334444, 1'b0}) begin
      err_cnt++;
      $display("FAIL long_lo: we=%b wa=%0d wd=%h ready=%b, want 1/4/33334444/0",
               rf_we, rf_wa, rf_wd, req_ready);
    end
    vec_cnt++;
    if ({pend1, pend2} !== 2'b11) begin
      err_cnt++;
      $display("FAIL long_lo_pend: pend1=%b pend2=%b, want 1/1", pend1, pend2);
    end
    vec_cnt++;
    if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !==
        {FWD, FWD ? 32'h11112222 : 32'h0, FWD, FWD ? 32'h33334444 : 32'h0}) begin
      err_cnt++;
      $display("FAIL long_lo_fwd: hit1=%b d1=%h hit2=%b d2=%h (fwd_en=%b)",
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, FWD);
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
    tick();
    vec_cnt++;
    if ({rf_we, rf_wa, rf_wd, req_ready, pend1, pend2} !==
        {1'b1, 4'd5, 32'h11112222, 1'b1, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL long_hi: we=%b wa=%0d wd=%h ready=%b p1=%b p2=%b, want 1/5/11112222/1/1/0",
               rf_we, rf_wa, rf_wd, req_ready, pend1, pend2);
    end
    tick();
    vec_cnt++;
    if ({rf_we, rf_model[4], rf_model[5]} !== {1'b0, 32'h33334444, 32'h11112222}) begin
      err_cnt++;
      $display("FAIL long_landed: we=%b r4=%h r5=%h, want 0/33334444/11112222",
               rf_we, rf_model[4], rf_model[5]);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = wr_count;
    ra1 = 4'd0;
    ra2 = 4'd0;
    drive(1'b1, 1'b1, 4'd1, 4'd2, 64'h2222_2222_1111_1111);
    tick();
    vec_cnt++;
    if ({rf_we, rf_wa, rf_wd, req_ready} !== {1'b1, 4'd1, 32'h11111111, 1'b0}) begin
      err_cnt++;
      $display("FAIL b2b_r1: we=%b wa=%0d wd=%h ready=%b", rf_we, rf_wa, rf_wd, req_ready);
    end
    drive(1'b1, 1'b0, 4'd7, 4'd0, 64'h0000_0000_7777_7777);
    tick();
    vec_cnt++;
    if ({rf_we, rf_wa, rf_wd, req_ready} !== {1'b1, 4'd2, 32'h22222222, 1'b1}) begin
      err_cnt++;
      $display("FAIL b2b_r2: we=%b wa=%0d wd=%h ready=%b", rf_we, rf_wa, rf_wd, req_ready);
    end
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
    vec_cnt++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd7, 32'h77777777}) begin
      err_cnt++;
      $display("FAIL b2b_r7: we=%b wa=%0d wd=%h", rf_we, rf_wa, rf_wd);
    end
    tick();
    vec_cnt++;
    if ((wr_count - base) !== 3 || rf_model[7] !== 32'h77777777) begin
      err_cnt++;
      $display("FAIL b2b_count: writes=%0d r7=%h, want 3/77777777", wr_count - base, rf_model[7]);
    end
  endtask

  task automatic test_pc();
    drive(1'b1, 1'b0, 4'd15, 4'd0, 64'h0000_0000_0000_0100);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
    ra1 = 4'd15;
    #1;
    vec_cnt++;
    if ({pc_we, pc_wd, rf_we} !== {1'b1, 32'h00000100, 1'b0}) begin
      err_cnt++;
      $display("FAIL pc_write: pc_we=%b pc_wd=%h rf_we=%b, want 1/00000100/0", pc_we, pc_wd, rf_we);
    end
    vec_cnt++;
    if ({pend1, fwd1_hit} !== 2'b00) begin
      err_cnt++;
      $display("FAIL pc_no_hazard: pend1=%b fwd1_hit=%b, want 0/0", pend1, fwd1_hit);
    end
    tick();
    vec_cnt++;
    if (pc_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL pc_clear: pc_we=%b want 0", pc_we);
    end
  endtask

  task automatic test_same_reg();
    drive(1'b1, 1'b1, 4'd6, 4'd6, 64'hAAAA_AAAA_5555_5555);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
    ra1 = 4'd6;
    #1;
    vec_cnt++;
    if ({rf_wa, rf_wd, pend1, fwd1_hit, fwd1_data} !==
        {4'd6, 32'h55555555, 1'b1, FWD, FWD ? 32'hAAAAAAAA : 32'h0}) begin
      err_cnt++;
      $display("FAIL same_lo: wa=%0d wd=%h pend=%b hit=%b fd=%h", rf_wa, rf_wd, pend1, fwd1_hit, fwd1_data);
    end
    tick();
    tick();
    vec_cnt++;
    if (rf_model[6] !== 32'hAAAAAAAA) begin
      err_cnt++;
      $display("FAIL same_final: r6=%h want aaaaaaaa", rf_model[6]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    drive(1'b1, 1'b1, 4'd4, 4'd5, 64'h1111_2222_3333_4444);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
    ra1 = 4'd5;
    #1;
    vec_cnt++;
    if ({rf_we, rf_wa, pend1} !== {1'b1, 4'd4, 1'b1}) begin
      err_cnt++;
      $display("FAIL rstmid_pre: we=%b wa=%0d pend1=%b, want 1/4/1", rf_we, rf_wa, pend1);
    end
    base  = wr_count;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({req_ready, rf_we, rf_wa, rf_wd, pc_we, pc_wd, pend1, fwd1_hit, fwd1_data} !== '0) begin
      err_cnt++;
      $display("FAIL rstmid_async: ready=%b we=%b wa=%0d wd=%h pc_we=%b pend1=%b hit=%b fd=%h",
               req_ready, rf_we, rf_wa, rf_wd, pc_we, pend1, fwd1_hit, fwd1_data);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if ((wr_count - base) !== 0 || rf_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL rstmid_dropped: writes=%0d we=%b, want 0/0", wr_count - base, rf_we);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_back_to_back();
    test_pc();
    test_same_reg();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
